screen_map_writer: RTL and testbench

Write-side client of the 64×320-bit screen tile map RAM that the display path reads each scanline. The RAM holds one row per 8-pixel tile line: 60 used rows, 80 columns × 4-bit tile index, with column c in bits [4c+3:4c]. This block accepts single-tile writes and whole-screen fill commands from the game/controller logic. It performs read-modify-write on the RAM's second port and commits only during blanking, so the display never reads a half-updated line.

---
 rtl/screen_map_writer_pkg.sv | 44 ++++
 rtl/screen_map_writer_merge.sv | 20 ++
 rtl/screen_map_writer.sv | 143 ++++++++++++++
 tb/tb_screen_map_writer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_map_writer_pkg.sv
// -----------------------------------------------------------------------------
// screen_map_writer_pkg
// Shared tile-map geometry, the writer FSM state type and the nibble insert
// helper. The display-side reader uses the same geometry constants.
//   MAP_ROWS / MAP_COLS : used tile rows / columns of the screen map
//   TILE_BITS           : bits per tile index (one nibble)
//   LINE_BITS           : width of one RAM row (80 tiles x 4 bits)
//   ADDR_BITS           : RAM row address width (64 physical rows)
// -----------------------------------------------------------------------------
package screen_map_writer_pkg;

  localparam int MAP_ROWS       = 60;
  localparam int MAP_COLS       = 80;
  localparam int TILE_BITS      = 4;
  localparam int LINE_BITS      = 320;
  localparam int ADDR_BITS      = 6;
  localparam int COL_BITS       = 7;
  localparam int TILES_PER_LINE = LINE_BITS / TILE_BITS;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    WRITE,
    FILL
  } state_t;

  // Replace the nibble of column col with tile; every other bit is preserved.
  // The bit offset 4*col needs 9 bits (max 316 for column 79).
  function automatic logic [LINE_BITS-1:0] nibble_insert(
    input logic [LINE_BITS-1:0] line,
    input logic [COL_BITS-1:0]  col,
    input logic [TILE_BITS-1:0] tile
  );
    logic [8:0]           offset;
    logic [LINE_BITS-1:0] mask;
    logic [LINE_BITS-1:0] value;
    offset = {col, 2'b00};
    mask   = {{(LINE_BITS-TILE_BITS){1'b0}}, {TILE_BITS{1'b1}}} << offset;
    value  = {{(LINE_BITS-TILE_BITS){1'b0}}, tile} << offset;
    return (line & ~mask) | value;
  endfunction

endpackage

// File: rtl/screen_map_writer_merge.sv
// -----------------------------------------------------------------------------
// tile_nibble_merge
// Combinational insert of one 4-bit tile index into a 320-bit map line.
//   line_in  : current line contents
//   col      : target column (0..79)
//   tile     : tile index to store
//   line_out : line with the target nibble replaced
// -----------------------------------------------------------------------------
module tile_nibble_merge
  import screen_map_writer_pkg::*;
(
  input  logic [LINE_BITS-1:0] line_in,
  input  logic [COL_BITS-1:0]  col,
  input  logic [TILE_BITS-1:0] tile,
  output logic [LINE_BITS-1:0] line_out
);

  assign line_out = nibble_insert(line_in, col, tile);

endmodule

// File: rtl/screen_map_writer.sv
// -----------------------------------------------------------------------------
// screen_map_writer
// Write-side client of the 64x320 screen tile map RAM (port B). Single-tile
// writes are done as read-modify-write; fills write every used row with one
// replicated tile. With BLANK_ONLY=1 the write strobe is gated by bright in
// the same cycle, so a RAM write can never land while the display is in its
// active area and the reader never sees a half-updated line.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   bright                 : display active-area flag
//   wr_valid/wr_ready      : single-tile write handshake (wr_row/col/tile)
//   fill_req/fill_tile     : level request to fill all rows with fill_tile
//   fill_busy              : a fill is in progress
//   done / err             : completion pulse / out-of-range drop pulse
//   mem_en/we/addr/din     : RAM port-B controls and write data
//   mem_dout               : RAM port-B read data (one cycle after a read)
// -----------------------------------------------------------------------------
module screen_map_writer
  import screen_map_writer_pkg::*;
#(
  parameter int ROWS       = MAP_ROWS,
  parameter int COLS       = MAP_COLS,
  parameter bit BLANK_ONLY = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bright,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [5:0]           wr_row,
  input  logic [6:0]           wr_col,
  input  logic [3:0]           wr_tile,
  input  logic                 fill_req,
  input  logic [3:0]           fill_tile,
  output logic                 fill_busy,
  output logic                 done,
  output logic                 err,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [5:0]           mem_addr,
  output logic [319:0]         mem_din,
  input  logic [319:0]         mem_dout
);

  state_t               state_q, state_d;
  logic                 rdy_q;
  logic                 err_q;
  logic                 fill_busy_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [LINE_BITS-1:0] mem_din_q;
  logic [COL_BITS-1:0]  col_q;
  logic [TILE_BITS-1:0] tile_q;
  logic [LINE_BITS-1:0] merged_line;

  logic gate_open;
  logic in_range;
  logic accept;
  logic fill_last;
  logic write_fire;

  assign wr_ready   = rdy_q & ~fill_req;
  assign gate_open  = !(BLANK_ONLY && bright);
  assign in_range   = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign accept     = (state_q == IDLE) && wr_valid && wr_ready;
  // mem_addr_q doubles as the fill row counter.
  assign fill_last  = (mem_addr_q == ADDR_BITS'(ROWS - 1));
  assign write_fire = gate_open && ((state_q == WRITE) || (state_q == FILL));

  assign mem_en    = (state_q == READ) || write_fire;
  assign mem_we    = write_fire;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  // write_fire implies WRITE or FILL, so outside WRITE only the last fill row counts.
  assign done      = write_fire && ((state_q == WRITE) || fill_last);
  assign err       = err_q;
  assign fill_busy = fill_busy_q;

  tile_nibble_merge u_merge (
    .line_in  (mem_dout),
    .col      (col_q),
    .tile     (tile_q),
    .line_out (merged_line)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fill_req)                  state_d = FILL;
        else if (accept && in_range)   state_d = READ;
      end
      READ:    state_d = CAPT;
      CAPT:    state_d = WRITE;
      WRITE:   if (gate_open) state_d = IDLE;
      FILL:    if (gate_open && fill_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the line buffer is an ordinary register (not a RAM array), so it is
  // reset with everything else; a reset mid-fill leaves nothing to resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
      fill_busy_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      col_q       <= '0;
      tile_q      <= '0;
    end else begin
      rdy_q       <= (state_d == IDLE);
      fill_busy_q <= (state_d == FILL);
      err_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fill_req) begin
            mem_addr_q <= '0;
            mem_din_q  <= {TILES_PER_LINE{fill_tile}};
          end else if (accept) begin
            col_q  <= wr_col;
            tile_q <= wr_tile;
            if (in_range) mem_addr_q <= wr_row;
            else          err_q      <= 1'b1;
          end
        end
        CAPT: mem_din_q <= merged_line;
        FILL: if (write_fire && !fill_last) mem_addr_q <= mem_addr_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_map_writer.sv
module tb_screen_map_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bright;
  logic         bright_man;
  logic         bright_r;
  logic         rand_en;
  logic         wr_valid;
  logic         wr_ready;
  logic [5:0]   wr_row;
  logic [6:0]   wr_col;
  logic [3:0]   wr_tile;
  logic         fill_req;
  logic [3:0]   fill_tile;
  logic         fill_busy;
  logic         done;
  logic         err;
  logic         mem_en;
  logic         mem_we;
  logic [5:0]   mem_addr;
  logic [319:0] mem_din;
  logic [319:0] ram_dout;

  // Bench-side RAM and its load controls
  logic [319:0] ram [64];
  logic         ram_clear;
  logic         ram_load;
  logic [5:0]   ram_load_row;
  logic [319:0] ram_load_data;

  // Reference model of the map contents
  logic [319:0] ref_ram [64];

  typedef struct { logic [5:0] addr; logic [319:0] din; } wlog_t;
  wlog_t wr_log[$];
  int    bright_viol = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign bright = rand_en ? bright_r : bright_man;

  screen_map_writer #(.ROWS(60), .COLS(80), .BLANK_ONLY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bright(bright),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_tile(wr_tile),
    .fill_req(fill_req), .fill_tile(fill_tile), .fill_busy(fill_busy),
    .done(done), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (ram_load) begin
      ram[ram_load_row] <= ram_load_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        ram_dout      <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_we) begin
      wr_log.push_back('{addr: mem_addr, din: mem_din});
      if (bright) bright_viol <= bright_viol + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    bright_r <= rand_en && ($urandom_range(0, 3) == 0);
  end

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [319:0] fill_line(input logic [3:0] t);
    logic [319:0] l;
    for (int i = 0; i < 80; i++) l[i*4 +: 4] = t;
    return l;
  endfunction

  // Issue one write; returns whether err/done was seen and done's cycle
  // number counted from the accept cycle (cycle 0).
  task automatic do_write(input logic [5:0] r, input logic [6:0] c, input logic [3:0] t,
                          output bit saw_err, output bit saw_done, output int done_cyc);
    int n;
    saw_err = 0; saw_done = 0; done_cyc = -1;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_row = r; wr_col = c; wr_tile = t;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 320'(n < 200), 320'(1));
    @(posedge clk); #1;
    wr_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (err) saw_err = 1;
      if (done) begin saw_done = 1; done_cyc = k; end
      if (saw_err || saw_done) break;
    end
  endtask

  task automatic ram_row_check(input string name, input int r);
    @(posedge clk); #1;
    check(name, ram[r], ref_ram[r]);
  endtask

  typedef struct {
    logic [5:0] row;
    logic [6:0] col;
    logic [3:0] tile;
    bit         exp_err;
  } vec_t;

  initial begin
    vec_t         tbl[8];
    logic [319:0] pat;
    bit           se, sd;
    int           dc, cnt, cnt2, base, n;
    logic [5:0]   rr;
    logic [6:0]   cc;
    logic [3:0]   tt;
    bit           xerr;

    rst_n = 1'b0; bright_man = 1'b0; rand_en = 1'b0;
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_tile = '0;
    fill_req = 1'b0; fill_tile = '0;
    ram_clear = 1'b1; ram_load = 1'b0; ram_load_row = '0; ram_load_data = '0;
    pat = {40{8'h5A}};
    for (int i = 0; i < 64; i++) ref_ram[i] = '0;
    ref_ram[59] = pat;

    @(posedge clk); #1;
    ram_clear = 1'b0; ram_load = 1'b1; ram_load_row = 6'd59; ram_load_data = pat;
    @(posedge clk); #1;
    ram_load = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wr_ready", 320'(wr_ready), 320'(0));
    check("rst_outs", 320'({fill_busy, done, err, mem_en, mem_we}), 320'(0));
    check("rst_addr", 320'(mem_addr), 320'(0));
    check("rst_din", mem_din, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_wr_ready", 320'(wr_ready), 320'(1));

    // Cycle-exact single write: row 0, col 0, tile A
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_row = 6'd0; wr_col = 7'd0; wr_tile = 4'hA;
    @(negedge clk);
    check("c0_ready", 320'({wr_ready, mem_en}), 320'(2'b10));
    @(posedge clk); #1; wr_valid = 1'b0;
    @(negedge clk);
    check("c1_read", 320'({mem_en, mem_we, mem_addr}), 320'({1'b1, 1'b0, 6'd0}));
    @(negedge clk);
    check("c2_idle_port", 320'({mem_en, mem_we}), 320'(0));
    @(negedge clk);
    check("c3_write", 320'({mem_en, mem_we, done, mem_addr}), 320'({3'b111, 6'd0}));
    check("c3_din", mem_din, 320'h0A);
    @(negedge clk);
    check("c4_ready", 320'({wr_ready, done, mem_we}), 320'(3'b100));
    ref_ram[0][3:0] = 4'hA;
    ram_row_check("c4_ram_row0", 0);

    // Table-driven writes, including both row-59 edge columns and rejects
    tbl[0] = '{row: 6'd59, col: 7'd79,  tile: 4'h3, exp_err: 1'b0};
    tbl[1] = '{row: 6'd59, col: 7'd0,   tile: 4'hE, exp_err: 1'b0};
    tbl[2] = '{row: 6'd59, col: 7'd40,  tile: 4'h1, exp_err: 1'b0};
    tbl[3] = '{row: 6'd0,  col: 7'd79,  tile: 4'hF, exp_err: 1'b0};
    tbl[4] = '{row: 6'd60, col: 7'd0,   tile: 4'h1, exp_err: 1'b1};
    tbl[5] = '{row: 6'd10, col: 7'd80,  tile: 4'h2, exp_err: 1'b1};
    tbl[6] = '{row: 6'd63, col: 7'd127, tile: 4'h4, exp_err: 1'b1};
    tbl[7] = '{row: 6'd30, col: 7'd1,   tile: 4'hB, exp_err: 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_write(tbl[i].row, tbl[i].col, tbl[i].tile, se, sd, dc);
      check($sformatf("tbl%0d_err", i), 320'(se), 320'(tbl[i].exp_err));
      check($sformatf("tbl%0d_done", i), 320'(sd), 320'(!tbl[i].exp_err));
      if (!tbl[i].exp_err) begin
        check($sformatf("tbl%0d_lat", i), 320'(dc), 320'(3));
        ref_ram[tbl[i].row][int'(tbl[i].col)*4 +: 4] = tbl[i].tile;
      end
      ram_row_check($sformatf("tbl%0d_ram", i), int'(tbl[i].row));
      if (i == 0) check("row59_top_nibble", 320'(ram[59][319:316]), 320'(3));
    end

    // Blank gating: bright high for 10 cycles after accept
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_row = 6'd5; wr_col = 7'd10; wr_tile = 4'h6;
    @(negedge clk);
    check("blank_c0_ready", 320'(wr_ready), 320'(1));
    cnt = 0; cnt2 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      wr_valid = 1'b0; bright_man = 1'b1;
      @(negedge clk);
      if (mem_we) cnt++;
      if (wr_ready) cnt2++;
    end
    check("blank_no_we", 320'(cnt), 320'(0));
    check("blank_not_ready", 320'(cnt2), 320'(0));
    @(posedge clk); #1; bright_man = 1'b0;
    @(negedge clk);
    check("blank_release", 320'({mem_we, done, mem_addr}), 320'({2'b11, 6'd5}));
    @(negedge clk);
    check("blank_ready_after", 320'(wr_ready), 320'(1));
    ref_ram[5][43:40] = 4'h6;
    ram_row_check("blank_ram", 5);

    // Reject timing: err the cycle after accept, wr_ready high with it
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_row = 6'd60; wr_col = 7'd3; wr_tile = 4'h9;
    @(negedge clk);
    @(posedge clk); #1; wr_valid = 1'b0;
    @(negedge clk);
    check("err_c1", 320'({err, wr_ready, mem_en}), 320'(3'b110));
    @(negedge clk);
    check("err_c2", 320'({err, mem_en}), 320'(0));

    // Randomized writes against the reference model with random blanking
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rr = 6'($urandom_range(0, 63));
      cc = 7'($urandom_range(0, 90));
      tt = 4'($urandom_range(0, 15));
      xerr = (rr >= 6'd60) || (cc >= 7'd80);
      do_write(rr, cc, tt, se, sd, dc);
      check($sformatf("rnd%0d_err", i), 320'(se), 320'(xerr));
      check($sformatf("rnd%0d_done", i), 320'(sd), 320'(!xerr));
      if (!xerr) ref_ram[rr][int'(cc)*4 +: 4] = tt;
      ram_row_check($sformatf("rnd%0d_ram", i), int'(rr));
    end
    rand_en = 1'b0;

    // Fill and write raised together: fill first, write after fill_busy falls
    @(posedge clk); #1;
    base = wr_log.size();
    fill_req = 1'b1; fill_tile = 4'h7;
    wr_valid = 1'b1; wr_row = 6'd3; wr_col = 7'd4; wr_tile = 4'h9;
    n = 0;
    @(negedge clk);
    while (!fill_busy && n < 20) begin @(negedge clk); n++; end
    check("fill_start", 320'({fill_busy, wr_ready}), 320'(2'b10));
    @(posedge clk); #1; fill_req = 1'b0;
    cnt = 0; n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      if (wr_ready) cnt++;
      @(negedge clk);
      n++;
    end
    check("fill_done_last", 320'({done, mem_we, mem_addr}), 320'({2'b11, 6'd59}));
    check("fill_no_early_ready", 320'(cnt), 320'(0));
    @(negedge clk);
    check("fill_end", 320'({fill_busy, wr_ready}), 320'(2'b01));
    @(posedge clk); #1; wr_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 50) begin @(negedge clk); n++; end
    check("post_fill_write_done", 320'(done), 320'(1));
    @(posedge clk); #1;
    for (int r = 0; r < 60; r++) ref_ram[r] = fill_line(4'h7);
    ref_ram[3][19:16] = 4'h9;
    check("fill_log_count", 320'(wr_log.size() - base), 320'(61));
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (base + i < wr_log.size()) begin
        if (wr_log[base+i].addr != 6'(i) || wr_log[base+i].din != fill_line(4'h7)) cnt++;
      end else cnt++;
    end
    check("fill_log_rows", 320'(cnt), 320'(0));
    if (base + 60 < wr_log.size())
      check("post_fill_log", 320'(wr_log[base+60].addr), 320'(3));
    else
      check("post_fill_log_missing", 320'(0), 320'(1));
    ram_row_check("post_fill_ram3", 3);

    // Reset during a fill at row 20
    @(posedge clk); #1;
    fill_req = 1'b1; fill_tile = 4'hC;
    n = 0;
    @(negedge clk);
    while (!fill_busy && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; fill_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(mem_we && mem_addr == 6'd20) && n < 200) begin @(negedge clk); n++; end
    check("fill_reached_row20", 320'(n < 200), 320'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_fill", 320'({mem_we, mem_en, fill_busy, done}), 320'(0));
    check("rst_mid_addr", 320'(mem_addr), 320'(0));
    for (int r = 0; r < 20; r++) ref_ram[r] = fill_line(4'hC);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_rst_idle", 320'({wr_ready, fill_busy, mem_we}), 320'(3'b100));

    // Whole-map comparison and blank-gate audit
    cnt = 0;
    for (int r = 0; r < 64; r++) if (ram[r] !== ref_ram[r]) cnt++;
    check("ram_final_rows", 320'(cnt), 320'(0));
    check("write_during_bright", 320'(bright_viol), 320'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
